// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the test-vector bus to asynchronous SRAM bridge:
// FSM state encoding and default geometry/timing.
package sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    RD_DONE  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH     = 20;
  localparam int unsigned DEF_DATA_WIDTH     = 16;
  localparam int unsigned DEF_RD_WAIT        = 2;
  localparam int unsigned DEF_WR_WAIT        = 2;
  localparam int unsigned DEF_WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/sram_bridge.sv
// Single-outstanding bridge from the test controller bus to a 16-bit asynchronous
// SRAM with fixed read/write wait timing; every SRAM-facing pin is registered.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned RD_WAIT        = DEF_RD_WAIT,
  parameter int unsigned WR_WAIT        = DEF_WR_WAIT,
  parameter int unsigned WAIT_CNT_WIDTH = DEF_WAIT_CNT_WIDTH,
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BE_WIDTH-1:0]   byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdataready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam logic [WAIT_CNT_WIDTH-1:0] RD_LOAD = WAIT_CNT_WIDTH'(RD_WAIT - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WR_LOAD = WAIT_CNT_WIDTH'(WR_WAIT - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE = WAIT_CNT_WIDTH'(1);

  state_t                    state, state_next;
  logic [WAIT_CNT_WIDTH-1:0] cnt, cnt_next;
  logic [BE_WIDTH-1:0]       be_q, be_next;
  logic [DATA_WIDTH-1:0]     rd_mask;
  logic                      ce_n_next, oe_n_next, we_n_next, ub_n_next, lb_n_next;
  logic                      dq_oe_next;
  logic                      rd_sample;

  // Decoded from registered state only; reset forces the bus to stall.
  assign waitrequest = reset | (state != IDLE);
  assign rd_sample   = (state == RD_ACC) && (cnt == '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    be_next    = be_q;
    unique case (state)
      IDLE: begin
        // A simultaneous read and write services the write only.
        if (write) begin
          state_next = WR_SETUP;
          be_next    = byteenable;
        end else if (read) begin
          state_next = RD_ACC;
          cnt_next   = RD_LOAD;
          be_next    = byteenable;
        end
      end
      RD_ACC: begin
        if (cnt == '0) state_next = RD_DONE;
        else           cnt_next   = cnt - CNT_ONE;
      end
      RD_DONE:  state_next = IDLE;
      WR_SETUP: begin
        state_next = WR_PULSE;
        cnt_next   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) state_next = WR_HOLD;
        else           cnt_next   = cnt - CNT_ONE;
      end
      WR_HOLD:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pin values are computed for the state being entered so they can be registered.
  always_comb begin
    ce_n_next  = 1'b1;
    oe_n_next  = 1'b1;
    we_n_next  = 1'b1;
    ub_n_next  = 1'b1;
    lb_n_next  = 1'b1;
    dq_oe_next = 1'b0;
    unique case (state_next)
      RD_ACC: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
        ub_n_next = ~be_next[BE_WIDTH-1];
        lb_n_next = ~be_next[0];
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_next  = 1'b0;
        dq_oe_next = 1'b1;
        ub_n_next  = ~be_next[BE_WIDTH-1];
        lb_n_next  = ~be_next[0];
      end
      WR_PULSE: begin
        ce_n_next  = 1'b0;
        we_n_next  = 1'b0;
        dq_oe_next = 1'b1;
        ub_n_next  = ~be_next[BE_WIDTH-1];
        lb_n_next  = ~be_next[0];
      end
      default: begin
        ce_n_next = 1'b1;
      end
    endcase
  end

  always_comb begin
    rd_mask = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      rd_mask[i*8 +: 8] = {8{be_q[i]}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      be_q          <= '0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      readdata      <= '0;
      readdataready <= 1'b0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      be_q          <= be_next;
      readdataready <= (state_next == RD_DONE);
      sram_dq_oe    <= dq_oe_next;
      sram_ce_n     <= ce_n_next;
      sram_oe_n     <= oe_n_next;
      sram_we_n     <= we_n_next;
      sram_ub_n     <= ub_n_next;
      sram_lb_n     <= lb_n_next;
      if ((state == IDLE) && (read || write)) sram_addr   <= address;
      if ((state == IDLE) && write)           sram_dq_out <= writedata;
      if (rd_sample)                          readdata    <= sram_dq_in & rd_mask;
    end
  end

endmodule
